// File: rtl/keypad_entry_if.sv
// rtl/keypad_entry_if.sv - keypad pins and entry-buffer outputs bundle
interface keypad_entry_if;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        clear;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [19:0] digits;
    logic [2:0]  cnt;
    logic        submit;

    // Drives the keypad rows and the clear request; observes the entry results
    modport master (
        output row_in, clear,
        input  col_out, key_valid, key_code, digits, cnt, submit
    );

    // The keypad_entry block itself
    modport slave (
        input  row_in, clear,
        output col_out, key_valid, key_code, digits, cnt, submit
    );
endinterface

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - 4x4 keypad scanner, debouncer and 5-digit entry buffer
module keypad_entry #(
    parameter int SCAN_DIV   = 100_000,
    parameter int DEBOUNCE   = 10,
    parameter int MAX_DIGITS = 5
) (
    input  logic           clk,
    input  logic           rst,
    keypad_entry_if.slave  kif
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_END  = DEB_W'(DEBOUNCE - 1);
    localparam logic [2:0]       CNT_MAX  = 3'(MAX_DIGITS);

    localparam logic [3:0] KEY_BACK  = 4'hE;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    typedef enum logic [1:0] {SCAN, DEB_P, PRESS, WAIT_R} state_t;

    state_t            state_q, state_d;
    logic [3:0]        rs1_q, rs_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DEB_W-1:0]  deb_q, deb_d;
    logic [1:0]        col_q, col_d;
    logic [1:0]        row_q, row_d;
    logic [3:0]        col_out_q, col_out_d;
    logic              key_valid_q, key_valid_d;
    logic [3:0]        key_code_q, key_code_d;
    logic [19:0]       digits_q, digits_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              submit_q, submit_d;

    logic              tick;
    logic              hit;
    logic [1:0]        hit_row;
    logic [3:0]        new_code;
    logic [4:0]        sh_put, sh_del;

    // Lowest-index active-low row wins when several rows are pulled down
    function automatic logic [1:0] low_row(input logic [3:0] r);
        if (!r[0])      return 2'd0;
        else if (!r[1]) return 2'd1;
        else if (!r[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    // Physical layout of the keypad: row-major, column 0 on the left
    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
            4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
            4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
            4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
        endcase
    endfunction

    assign tick     = (div_q == DIV_LAST);
    assign hit      = (rs_q != 4'hF);
    assign hit_row  = low_row(rs_q);
    assign new_code = key_lookup(row_q, col_q);
    // Bit offset of the next free nibble and of the last filled nibble
    assign sh_put   = 5'd16 - {cnt_q, 2'b00};
    assign sh_del   = 5'd20 - {cnt_q, 2'b00};

    // Next-state logic: scan/debounce FSM, then buffer edits; clear has the last word on the buffer
    always_comb begin
        state_d     = state_q;
        div_d       = tick ? '0 : div_q + 1'b1;
        deb_d       = deb_q;
        col_d       = col_q;
        row_d       = row_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        digits_d    = digits_q;
        cnt_d       = cnt_q;
        submit_d    = 1'b0;

        case (state_q)
            SCAN: begin
                if (tick) begin
                    if (hit) begin
                        row_d   = hit_row;
                        deb_d   = '0;
                        state_d = DEB_P;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
            end
            DEB_P: begin
                if (tick) begin
                    if (hit && (hit_row == row_q)) begin
                        if (deb_q == DEB_END) begin
                            // Outputs are registered, so the pulse lines up with the PRESS cycle
                            state_d     = PRESS;
                            key_valid_d = 1'b1;
                            key_code_d  = new_code;
                            submit_d    = (new_code == KEY_ENTER) && !kif.clear;
                        end else begin
                            deb_d = deb_q + 1'b1;
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = col_q + 2'd1;
                    end
                end
            end
            PRESS: begin
                state_d = WAIT_R;
                deb_d   = '0;
                if (key_code_q <= 4'd9) begin
                    if (cnt_q < CNT_MAX) begin
                        digits_d = digits_q | ({16'b0, key_code_q} << sh_put);
                        cnt_d    = cnt_q + 3'd1;
                    end
                end else if (key_code_q == KEY_BACK) begin
                    if (cnt_q != 3'd0) begin
                        digits_d = digits_q & ~(20'hF << sh_del);
                        cnt_d    = cnt_q - 3'd1;
                    end
                end else if (key_code_q == KEY_ENTER) begin
                    digits_d = '0;
                    cnt_d    = '0;
                end
            end
            WAIT_R: begin
                if (tick) begin
                    if (!hit) begin
                        if (deb_q == DEB_END) begin
                            state_d = SCAN;
                            col_d   = col_q + 2'd1;
                        end else begin
                            deb_d = deb_q + 1'b1;
                        end
                    end else begin
                        deb_d = '0;
                    end
                end
            end
            default: state_d = SCAN;
        endcase

        if (kif.clear) begin
            digits_d = '0;
            cnt_d    = '0;
        end

        col_out_d = ~(4'b0001 << col_d);
    end

    // State registers plus the two-stage row synchronizer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SCAN;
            rs1_q       <= 4'hF;
            rs_q        <= 4'hF;
            div_q       <= '0;
            deb_q       <= '0;
            col_q       <= 2'd0;
            row_q       <= 2'd0;
            col_out_q   <= 4'b1110;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            digits_q    <= '0;
            cnt_q       <= '0;
            submit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rs1_q       <= kif.row_in;
            rs_q        <= rs1_q;
            div_q       <= div_d;
            deb_q       <= deb_d;
            col_q       <= col_d;
            row_q       <= row_d;
            col_out_q   <= col_out_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            digits_q    <= digits_d;
            cnt_q       <= cnt_d;
            submit_q    <= submit_d;
        end
    end

    assign kif.col_out   = col_out_q;
    assign kif.key_valid = key_valid_q;
    assign kif.key_code  = key_code_q;
    assign kif.digits    = digits_q;
    assign kif.cnt       = cnt_q;
    assign kif.submit    = submit_q;
endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - directed self-checking bench for keypad_entry
module tb_keypad_entry;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    keypad_entry_if kif();

    keypad_entry #(.SCAN_DIV(4), .DEBOUNCE(3), .MAX_DIGITS(5)) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    // Keypad model: a held key pulls its row low only while its column is driven
    logic       key_down = 1'b0;
    logic       glitch   = 1'b0;
    logic [1:0] key_r    = 2'd0;
    logic [1:0] key_c    = 2'd0;
    assign kif.row_in = glitch ? 4'b1110 :
                        (key_down && (kif.col_out[key_c] == 1'b0)) ? ~(4'b0001 << key_r) : 4'hF;

    int total = 0;
    int bad   = 0;

    int          npulse, nsub;
    logic [3:0]  cap_code;
    logic        cap_sub;
    logic [19:0] cap_dig, post_dig;
    logic [2:0]  cap_cnt, post_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_key(input logic [3:0] code);
        case (code)
            4'h1: begin key_r = 2'd0; key_c = 2'd0; end
            4'h2: begin key_r = 2'd0; key_c = 2'd1; end
            4'h3: begin key_r = 2'd0; key_c = 2'd2; end
            4'hA: begin key_r = 2'd0; key_c = 2'd3; end
            4'h4: begin key_r = 2'd1; key_c = 2'd0; end
            4'h5: begin key_r = 2'd1; key_c = 2'd1; end
            4'h6: begin key_r = 2'd1; key_c = 2'd2; end
            4'hB: begin key_r = 2'd1; key_c = 2'd3; end
            4'h7: begin key_r = 2'd2; key_c = 2'd0; end
            4'h8: begin key_r = 2'd2; key_c = 2'd1; end
            4'h9: begin key_r = 2'd2; key_c = 2'd2; end
            4'hC: begin key_r = 2'd2; key_c = 2'd3; end
            4'hE: begin key_r = 2'd3; key_c = 2'd0; end
            4'h0: begin key_r = 2'd3; key_c = 2'd1; end
            4'hF: begin key_r = 2'd3; key_c = 2'd2; end
            default: begin key_r = 2'd3; key_c = 2'd3; end
        endcase
    endtask

    // Hold a key for 'hold' cycles, release, and watch 40 more cycles
    task automatic press(input logic [3:0] code, input int hold);
        logic want_post;
        want_post = 1'b0;
        npulse = 0;
        nsub   = 0;
        set_key(code);
        key_down = 1'b1;
        for (int i = 0; i < hold + 40; i++) begin
            if (i == hold) key_down = 1'b0;
            @(negedge clk);
            if (want_post) begin
                post_dig  = kif.digits;
                post_cnt  = kif.cnt;
                want_post = 1'b0;
            end
            if (kif.key_valid) begin
                npulse++;
                cap_code  = kif.key_code;
                cap_sub   = kif.submit;
                cap_dig   = kif.digits;
                cap_cnt   = kif.cnt;
                want_post = 1'b1;
            end
            if (kif.submit) nsub++;
        end
    endtask

    task automatic do_clear();
        kif.clear = 1'b1;
        @(negedge clk);
        kif.clear = 1'b0;
    endtask

    initial begin
        kif.clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_col", 32'(kif.col_out), 32'hE);
        chk("rst_kv", 32'(kif.key_valid), 32'h0);
        chk("rst_code", 32'(kif.key_code), 32'h0);
        chk("rst_dig", 32'(kif.digits), 32'h0);
        chk("rst_cnt", 32'(kif.cnt), 32'h0);
        chk("rst_sub", 32'(kif.submit), 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        press(4'h6, 40);
        chk("k6_pulses", 32'(npulse), 32'd1);
        chk("k6_code", 32'(cap_code), 32'h6);
        chk("k6_dig", 32'(kif.digits), 32'h60000);
        chk("k6_cnt", 32'(kif.cnt), 32'd1);

        do_clear();
        chk("clr_dig", 32'(kif.digits), 32'h0);
        chk("clr_cnt", 32'(kif.cnt), 32'd0);

        for (int k = 1; k <= 5; k++) press(4'(k), 40);
        chk("full_dig", 32'(kif.digits), 32'h12345);
        chk("full_cnt", 32'(kif.cnt), 32'd5);
        press(4'h6, 40);
        chk("ovf_pulses", 32'(npulse), 32'd1);
        chk("ovf_code", 32'(cap_code), 32'h6);
        chk("ovf_dig", 32'(kif.digits), 32'h12345);
        chk("ovf_cnt", 32'(kif.cnt), 32'd5);

        do_clear();
        press(4'h7, 40);
        press(4'h8, 40);
        chk("78_dig", 32'(kif.digits), 32'h78000);
        press(4'hE, 40);
        chk("bs1_dig", 32'(kif.digits), 32'h70000);
        chk("bs1_cnt", 32'(kif.cnt), 32'd1);
        press(4'hE, 40);
        chk("bs2_dig", 32'(kif.digits), 32'h0);
        chk("bs2_cnt", 32'(kif.cnt), 32'd0);
        press(4'hE, 40);
        chk("bs3_pulses", 32'(npulse), 32'd1);
        chk("bs3_dig", 32'(kif.digits), 32'h0);
        chk("bs3_cnt", 32'(kif.cnt), 32'd0);

        press(4'h9, 40);
        press(4'h0, 40);
        press(4'hF, 40);
        chk("ent_pulses", 32'(npulse), 32'd1);
        chk("ent_subs", 32'(nsub), 32'd1);
        chk("ent_sub_kv", 32'(cap_sub), 32'd1);
        chk("ent_dig", 32'(cap_dig), 32'h90000);
        chk("ent_cnt", 32'(cap_cnt), 32'd2);
        chk("ent_post_dig", 32'(post_dig), 32'h0);
        chk("ent_post_cnt", 32'(post_cnt), 32'd0);

        npulse = 0;
        glitch = 1'b1;
        repeat (5) @(negedge clk);
        glitch = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (kif.key_valid) npulse++;
        end
        chk("glitch_pulses", 32'(npulse), 32'd0);

        press(4'h3, 500);
        chk("hold_pulses", 32'(npulse), 32'd1);
        chk("hold_dig", 32'(kif.digits), 32'h30000);
        press(4'h5, 40);
        chk("k35_dig", 32'(kif.digits), 32'h35000);
        chk("k35_cnt", 32'(kif.cnt), 32'd2);

        kif.clear = 1'b1;
        press(4'hF, 40);
        kif.clear = 1'b0;
        chk("clrF_pulses", 32'(npulse), 32'd1);
        chk("clrF_subs", 32'(nsub), 32'd0);
        chk("clrF_code", 32'(cap_code), 32'hF);
        chk("clrF_cnt", 32'(kif.cnt), 32'd0);
        chk("clrF_dig", 32'(kif.digits), 32'h0);

        press(4'h2, 40);
        chk("k2_dig", 32'(kif.digits), 32'h20000);
        chk("k2_code", 32'(kif.key_code), 32'h2);
        // Line the held key up with a fresh column-0 slot so the FSM sits in DEB_P
        set_key(4'h1);
        key_down = 1'b1;
        for (int i = 0; i < 40 && kif.col_out == 4'b1110; i++) @(negedge clk);
        for (int i = 0; i < 40 && kif.col_out != 4'b1110; i++) @(negedge clk);
        chk("align_col", 32'(kif.col_out), 32'hE);
        repeat (6) @(negedge clk);
        chk("deb_no_kv", 32'(kif.key_valid), 32'h0);
        rst = 1'b0;
        #1;
        chk("mid_col", 32'(kif.col_out), 32'hE);
        chk("mid_kv", 32'(kif.key_valid), 32'h0);
        chk("mid_code", 32'(kif.key_code), 32'h0);
        chk("mid_dig", 32'(kif.digits), 32'h0);
        chk("mid_cnt", 32'(kif.cnt), 32'd0);
        chk("mid_sub", 32'(kif.submit), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        press(4'h1, 40);
        chk("repress_pulses", 32'(npulse), 32'd1);
        chk("repress_code", 32'(cap_code), 32'h1);
        chk("repress_dig", 32'(kif.digits), 32'h10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
